data_mem_bridge: RTL and testbench
==================================

// Module: data_mem_bridge
// PURPOSE
//  Sits directly downstream of the CPU data port; turns the CPU's single-cycle load/store port into req/ready memory transactions.
//  Stores are posted into a BufferDepth-entry FIFO, so the CPU proceeds without waiting for memory.
//  Loads drain the FIFO first (strict program order), then issue a read and stall the CPU until data returns.
//  The CPU's enable input is driven from ~stall.
// PARAMETERS
//  DataWidth    32  width of data, write mask and address
//  BufferDepth  4   store FIFO entries; power of two, >= 2
// PORTS
//  clock      in   1          clock; all state updates on posedge
//  reset      in   1          asynchronous, active-low reset
//  cpuWrite   in   1          CPU store this cycle
//  cpuRead    in   1          CPU load this cycle; held high while stall=1
//  cpuAddr    in   DataWidth  byte address (already offset-corrected by the CPU)
//  cpuWData   in   DataWidth  store data
//  cpuWMask   in   DataWidth  per-bit store mask
//  cpuRData   out  DataWidth  load data; valid only while state==READ_DONE
//  stall      out  1          1 = CPU must hold its current instruction
//  memReq     out  1          transaction request
//  memWrite   out  1          1 = write, 0 = read; qualified by memReq
//  memAddr    out  DataWidth  transaction address
//  memWData   out  DataWidth  write data
//  memWMask   out  DataWidth  write mask
//  memReady   in   1          memory accepts the request this cycle (memReq & memReady = transfer)
//  memRData   in   DataWidth  read data; qualified by memRValid
//  memRValid  in   1          read data valid
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - FIFO emptied (count=0, pointers 0); state=IDLE.
//   - All registered outputs cleared: memReq, memWrite, memAddr, memWData, memWMask, cpuRData = 0.
//   - stall=0 while reset is low.
//   - Reset mid-transaction drops the outstanding request; memory is reset in the same domain.
//  Store path:
//   - Push {cpuAddr, cpuWData, cpuWMask} at the posedge when cpuWrite=1 and stall=0.
//   - full (count==BufferDepth) stalls a store, even if a pop occurs in the same cycle.
//   - Push and pop in the same cycle when not full: count unchanged.
//  Write issue:
//   - In IDLE or DRAIN with FIFO non-empty: memReq=1, memWrite=1; memAddr/WData/WMask = FIFO head.
//   - All request outputs are registered and held stable until memReady=1.
//   - On the transfer edge: pop; the next head, if any, is presented the following cycle (one write per 2 cycles min).
//  Load FSM (states: IDLE, DRAIN, READ_REQ, READ_WAIT, READ_DONE):
//   - IDLE -> DRAIN when cpuRead=1 and FIFO non-empty.
//   - IDLE -> READ_REQ when cpuRead=1 and FIFO empty.
//   - DRAIN -> READ_REQ on the edge where the last entry transfers (count 1 -> 0).
//   - READ_REQ: memReq=1, memWrite=0, memAddr=cpuAddr; -> READ_WAIT on memReady=1.
//   - READ_WAIT: memReq=0; memRValid is sampled here only (earliest 1 cycle after acceptance).
//   - READ_WAIT -> READ_DONE on memRValid=1; memRData is captured into cpuRData on that edge.
//   - READ_DONE: stall=0; the CPU retires the load at this edge; -> IDLE unconditionally.
//   - stall = (cpuWrite & full) | (cpuRead & state!=READ_DONE); combinational.
//   - Load latency with empty FIFO and zero-wait memory: 3 stall cycles.
//   - No store-to-load forwarding; ordering is guaranteed by drain-first.
//  Error cases:
//   - cpuWrite & cpuRead both high is illegal; handled as a store and a simulation assertion fires.
//   - memRValid outside READ_WAIT is ignored.
// TESTING
//  1. Reset low mid-READ_WAIT -> memReq=0, stall=0, count=0 immediately, no clock needed.
//  2. 4 stores, memReady=0 -> no stall on stores 1-4; 5th store stalls; memReady=1 one cycle -> stall drops the next cycle.
//  3. Store A=0x10,D=0xAABBCCDD then load 0x10, memReady=1 -> write 0x10 transfers before read req 0x10; stall high through READ_WAIT.
//  4. Empty FIFO, load 0x20, memReady=1, memRValid one cycle later with 0x12345678 -> stall 3 cycles; cpuRData=0x12345678 in READ_DONE.
//  5. memReady held 0 for 5 cycles during a write -> memAddr/WData/WMask constant; exactly one pop on accept.
//  6. Push at full-1 while popping -> count unchanged; head/tail wrap after 9 alternating push/pop with data intact.

Source files
------------

// File: rtl/data_mem_bridge.sv
// data_mem_bridge
//   Sits between the CPU data port and a req/ready memory. Stores are posted
//   into a small FIFO so the CPU keeps running; loads first drain the FIFO
//   (program order), then issue a read and stall the CPU until data returns.
//
// Ports
//   clock, reset          clock (posedge) and asynchronous active-low reset
//   cpuWrite / cpuRead    CPU store / load this cycle (cpuRead held while stalled)
//   cpuAddr               byte address for store or load
//   cpuWData / cpuWMask   store data and per-bit mask
//   cpuRData              load data, valid while the load is being retired
//   stall                 CPU must hold its current instruction
//   memReq / memWrite     registered request, 1 = write / 0 = read
//   memAddr/WData/WMask   registered request payload, stable until accepted
//   memReady              memory accepts the request (memReq & memReady)
//   memRData / memRValid  read return, sampled only while waiting for it
module data_mem_bridge #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned BufferDepth = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpuWrite,
  input  logic                 cpuRead,
  input  logic [DataWidth-1:0] cpuAddr,
  input  logic [DataWidth-1:0] cpuWData,
  input  logic [DataWidth-1:0] cpuWMask,
  output logic [DataWidth-1:0] cpuRData,
  output logic                 stall,
  output logic                 memReq,
  output logic                 memWrite,
  output logic [DataWidth-1:0] memAddr,
  output logic [DataWidth-1:0] memWData,
  output logic [DataWidth-1:0] memWMask,
  input  logic                 memReady,
  input  logic [DataWidth-1:0] memRData,
  input  logic                 memRValid
);

  localparam int unsigned PtrW = $clog2(BufferDepth);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    READ_REQ,
    READ_WAIT,
    READ_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DataWidth-1:0] r_fifo_addr [BufferDepth];
  logic [DataWidth-1:0] r_fifo_data [BufferDepth];
  logic [DataWidth-1:0] r_fifo_mask [BufferDepth];
  logic [PtrW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [PtrW:0]        r_count, w_count_nxt;

  logic                 r_mem_req, r_mem_write;
  logic [DataWidth-1:0] r_mem_addr, r_mem_wdata, r_mem_wmask, r_cpu_rdata;

  logic w_full, w_rd, w_stall, w_push, w_pop, w_issue_wr, w_issue_rd;

  // A simultaneous load and store is treated purely as a store.
  assign w_rd    = cpuRead & ~cpuWrite;
  assign w_full  = (r_count == (PtrW+1)'(BufferDepth));
  assign w_stall = reset & ((cpuWrite & w_full) | (w_rd & (r_state != READ_DONE)));
  assign w_push  = cpuWrite & ~w_stall;
  assign w_pop   = r_mem_req & r_mem_write & memReady;
  assign w_count_nxt = r_count + (PtrW+1)'(w_push) - (PtrW+1)'(w_pop);

  // New write only from an idle request slot, so a transfer is always
  // followed by one request-free cycle before the next head is presented.
  assign w_issue_wr = ~r_mem_req & ((r_state == IDLE) | (r_state == DRAIN)) &
                      (r_count != '0);
  assign w_issue_rd = (w_state_nxt == READ_REQ) & (r_state != READ_REQ);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      // If the only buffered store leaves on this very edge, go straight to
      // the read rather than parking in DRAIN with nothing left to drain.
      IDLE:      if (w_rd) w_state_nxt = (w_count_nxt == '0) ? READ_REQ : DRAIN;
      DRAIN:     if (w_count_nxt == '0) w_state_nxt = READ_REQ;
      READ_REQ:  if (memReady) w_state_nxt = READ_WAIT;
      READ_WAIT: if (memRValid) w_state_nxt = READ_DONE;
      READ_DONE: w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cpu_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if ((r_state == READ_WAIT) && memRValid) r_cpu_rdata <= memRData;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= cpuAddr;
      r_fifo_data[r_wr_ptr] <= cpuWData;
      r_fifo_mask[r_wr_ptr] <= cpuWMask;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mem_req   <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
    end else if (w_issue_rd) begin
      r_mem_req   <= 1'b1;
      r_mem_write <= 1'b0;
      r_mem_addr  <= cpuAddr;
    end else if (w_issue_wr) begin
      r_mem_req   <= 1'b1;
      r_mem_write <= 1'b1;
      r_mem_addr  <= r_fifo_addr[r_rd_ptr];
      r_mem_wdata <= r_fifo_data[r_rd_ptr];
      r_mem_wmask <= r_fifo_mask[r_rd_ptr];
    end else if (r_mem_req && memReady) begin
      r_mem_req <= 1'b0;
    end
  end

  assign memReq   = r_mem_req;
  assign memWrite = r_mem_write;
  assign memAddr  = r_mem_addr;
  assign memWData = r_mem_wdata;
  assign memWMask = r_mem_wmask;
  assign cpuRData = r_cpu_rdata;
  assign stall    = w_stall;

  a_no_load_and_store: assert property (@(posedge clock) disable iff (!reset)
    !(cpuWrite && cpuRead));

endmodule

// File: tb/tb_data_mem_bridge.sv
module tb_data_mem_bridge;

  logic        clock, reset;
  logic        cpuWrite, cpuRead;
  logic [31:0] cpuAddr, cpuWData, cpuWMask, cpuRData;
  logic        stall, memReq, memWrite;
  logic [31:0] memAddr, memWData, memWMask;
  logic        memReady, memRValid;
  logic [31:0] memRData;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] m;
  } wr_t;
  wr_t exp_q[$];

  data_mem_bridge #(.DataWidth(32), .BufferDepth(4)) dut (
    .clock(clock), .reset(reset),
    .cpuWrite(cpuWrite), .cpuRead(cpuRead), .cpuAddr(cpuAddr),
    .cpuWData(cpuWData), .cpuWMask(cpuWMask), .cpuRData(cpuRData),
    .stall(stall), .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr),
    .memWData(memWData), .memWMask(memWMask), .memReady(memReady),
    .memRData(memRData), .memRValid(memRValid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
    cpuWrite = 1'b1;
    cpuAddr  = a;
    cpuWData = d;
    cpuWMask = m;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
    wr_t e;
    e.a = a; e.d = d; e.m = m;
    exp_q.push_back(e);
  endtask

  // Store accepted at the next edge: drive it, check no stall, record it.
  task automatic store_ok(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] m);
    set_store(a, d, m);
    #1;
    chk(tag, stall, 0);
    cyc();
    push_exp(a, d, m);
    cpuWrite = 1'b0;
  endtask

  task automatic drain(input string tag);
    memReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (dut.r_count == 0 && !memReq) break;
      cyc();
    end
    chk(tag, dut.r_count, 0);
    chk({tag, "_q"}, exp_q.size(), 0);
    memReady = 1'b0;
  endtask

  // Write scoreboard: inputs are stable from posedge+1, so a transfer seen
  // here happens at the coming posedge.
  always @(negedge clock) begin
    if (reset && memReq && memWrite && memReady) begin
      if (exp_q.size() == 0) begin
        chk("spurious_wr", 1, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", memAddr, e.a);
        chk("wr_data", memWData, e.d);
        chk("wr_mask", memWMask, e.m);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; cpuWrite = 1'b0; cpuRead = 1'b0;
    cpuAddr = '0; cpuWData = '0; cpuWMask = '0;
    memReady = 1'b0; memRValid = 1'b0; memRData = '0;

    // Reset state
    #13;
    chk("rst_memReq", memReq, 0);
    chk("rst_memWrite", memWrite, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_cpuRData", cpuRData, 0);
    chk("rst_stall", stall, 0);
    @(negedge clock);
    reset = 1'b1;
    cyc();

    // Load with empty FIFO, zero-wait memory: 3 stall cycles
    memReady = 1'b1; cpuRead = 1'b1; cpuAddr = 32'h20;
    #1;
    chk("ld_stall_c0", stall, 1);
    cyc();
    chk("ld_req", memReq, 1);
    chk("ld_req_rd", memWrite, 0);
    chk("ld_req_addr", memAddr, 32'h20);
    chk("ld_stall_c1", stall, 1);
    cyc();
    chk("ld_wait_req", memReq, 0);
    chk("ld_stall_c2", stall, 1);
    memReady = 1'b0; memRValid = 1'b1; memRData = 32'h12345678;
    cyc();
    chk("ld_done_stall", stall, 0);
    chk("ld_done_rdata", cpuRData, 32'h12345678);
    cpuRead = 1'b0; memRData = 32'hDEADBEEF;
    cyc();
    chk("ld_rvalid_ignored", cpuRData, 32'h12345678);
    memRValid = 1'b0;

    // Store then load same address: write goes out before the read
    memReady = 1'b1;
    store_ok("sl_store_stall", 32'h10, 32'hAABBCCDD, 32'hFFFFFFFF);
    cpuRead = 1'b1; cpuAddr = 32'h10;
    #1;
    chk("sl_stall_idle", stall, 1);
    cyc();
    chk("sl_wr_req", memReq, 1);
    chk("sl_wr_is_write", memWrite, 1);
    chk("sl_wr_addr", memAddr, 32'h10);
    chk("sl_wr_data", memWData, 32'hAABBCCDD);
    chk("sl_stall_drain", stall, 1);
    cyc();
    chk("sl_rd_req", memReq, 1);
    chk("sl_rd_is_read", memWrite, 0);
    chk("sl_rd_addr", memAddr, 32'h10);
    chk("sl_count", dut.r_count, 0);
    chk("sl_stall_rdreq", stall, 1);
    cyc();
    memReady = 1'b0;
    chk("sl_wait_req", memReq, 0);
    chk("sl_stall_wait1", stall, 1);
    cyc();
    chk("sl_stall_wait2", stall, 1);
    memRValid = 1'b1; memRData = 32'h55AA55AA;
    cyc();
    chk("sl_done_stall", stall, 0);
    chk("sl_done_rdata", cpuRData, 32'h55AA55AA);
    cpuRead = 1'b0; memRValid = 1'b0;
    cyc();
    chk("sl_q_empty", exp_q.size(), 0);

    // Fill the FIFO with memory stalled; 5th store stalls
    memReady = 1'b0;
    store_ok("full_st1", 32'h100, 32'hA0000001, 32'h000000FF);
    store_ok("full_st2", 32'h104, 32'hA0000002, 32'h0000FF00);
    store_ok("full_st3", 32'h108, 32'hA0000003, 32'h00FF0000);
    store_ok("full_st4", 32'h10C, 32'hA0000004, 32'hFF000000);
    chk("full_count", dut.r_count, 4);
    set_store(32'h110, 32'hA0000005, 32'h0F0F0F0F);
    #1;
    chk("full_st5_stall", stall, 1);
    memReady = 1'b1;
    #1;
    chk("full_stall_with_pop", stall, 1);
    cyc();
    memReady = 1'b0;
    #1;
    chk("full_stall_drops", stall, 0);
    chk("full_count_after_pop", dut.r_count, 3);
    cyc();
    push_exp(32'h110, 32'hA0000005, 32'h0F0F0F0F);
    cpuWrite = 1'b0;
    chk("full_count_refill", dut.r_count, 4);

    // Request held stable for 5 cycles of memReady=0, then exactly one pop
    chk("hold_req", memReq, 1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_addr", memAddr, 32'h104);
      chk("hold_data", memWData, 32'hA0000002);
      chk("hold_mask", memWMask, 32'h0000FF00);
      cyc();
    end
    memReady = 1'b1;
    cyc();
    memReady = 1'b0;
    chk("hold_one_pop", dut.r_count, 3);
    chk("hold_gap", memReq, 0);
    cyc();
    chk("hold_next_req", memReq, 1);
    chk("hold_next_addr", memAddr, 32'h108);
    chk("hold_next_count", dut.r_count, 3);
    drain("full_drain");

    // Push at full-1 while popping: count unchanged
    store_ok("pp_st1", 32'h200, 32'hB0000001, 32'h11111111);
    store_ok("pp_st2", 32'h204, 32'hB0000002, 32'h22222222);
    store_ok("pp_st3", 32'h208, 32'hB0000003, 32'h33333333);
    chk("pp_count3", dut.r_count, 3);
    chk("pp_req", memReq, 1);
    memReady = 1'b1;
    store_ok("pp_st4", 32'h20C, 32'hB0000004, 32'h44444444);
    memReady = 1'b0;
    chk("pp_count_same", dut.r_count, 3);
    drain("pp_drain");

    // 9 alternating push/pop rounds: pointers wrap, data checked in order
    memReady = 1'b1;
    for (int i = 0; i < 9; i++) begin
      store_ok("wrap_st", 32'h300 + 32'(i) * 4, 32'hC0DE0000 + 32'(i), ~(32'h1 << i));
      cyc();
    end
    drain("wrap_drain");

    // Reset while a write request is pending
    store_ok("rw_st1", 32'h400, 32'hD0000001, 32'hFFFFFFFF);
    store_ok("rw_st2", 32'h404, 32'hD0000002, 32'hFFFFFFFF);
    chk("rw_pre_req", memReq, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rw_req", memReq, 0);
    chk("rw_count", dut.r_count, 0);
    chk("rw_addr", memAddr, 0);
    exp_q.delete();
    @(posedge clock);
    #3;
    reset = 1'b1;
    cyc();
    cyc();
    chk("rw_after_req", memReq, 0);
    chk("rw_after_count", dut.r_count, 0);

    // Reset mid-READ_WAIT
    cpuRead = 1'b1; cpuAddr = 32'h40; memReady = 1'b1;
    cyc();
    cyc();
    memReady = 1'b0;
    #1;
    chk("rr_pre_stall", stall, 1);
    chk("rr_pre_addr", memAddr, 32'h40);
    reset = 1'b0;
    #1;
    chk("rr_stall", stall, 0);
    chk("rr_req", memReq, 0);
    chk("rr_addr", memAddr, 0);
    chk("rr_count", dut.r_count, 0);
    chk("rr_rdata", cpuRData, 0);
    cpuRead = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b1;
    cyc();
    memRValid = 1'b1; memRData = 32'h00000999;
    cyc();
    cyc();
    chk("rr_rvalid_ignored", cpuRData, 0);
    chk("rr_idle_req", memReq, 0);
    memRValid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
